rr_request_arbiter: RTL
=======================

// Module: rr_request_arbiter
// PURPOSE
//   Round-robin arbiter that shares one downstream resource among N requesters.
//   Replaces the fixed-priority, combinational index encoder with a fair, registered scheduler.
//   Grants one requester at a time and holds the grant until release, drop or timeout.
//   Publishes the one-hot grant plus its binary index on the dedicated outputs of the top level.
// PARAMETERS
//   N        15   number of requesters; legal range 2..15
//   IDW      4    grant_id width; must satisfy 2**IDW >= N
//   TIMEOUT  255  max GRANT cycles before forced release; 0 disables timeout
//   TW       8    hold-timer width; must satisfy 2**TW > TIMEOUT
// PORTS
//   clk          in   1    single clock, rising edge
//   rst_n        in   1    asynchronous reset, active-low
//   en           in   1    arbitration enable (same role as the encoder's MSB valid bit)
//   req          in   N    request vector, level-sensitive, bit i = requester i
//   done         in   1    release strobe from the current grantee
//   grant        out  N    one-hot grant, registered; all zeros when idle
//   grant_id     out  IDW  binary index of grantee; 0 when grant_valid=0
//   grant_valid  out  1    high while in GRANT
//   timeout_evt  out  1    one-cycle pulse on forced release by timeout
// BEHAVIOUR
//   Reset (async assert, sync-to-clk deassert by top level):
//     state=IDLE; grant=0; grant_id=0; grant_valid=0; timeout_evt=0; timer=0; last_id=N-1.
//   States: IDLE, GRANT. All outputs are registered; there is no comb path from input to output.
//   IDLE:
//     - If en=1 and |req: pick the first set req bit scanning last_id+1, +2, ... mod N.
//     - A search that wraps past N-1 continues at index 0.
//     - At that edge: grant=1<<k, grant_id=k, grant_valid=1, timer=0, go to GRANT.
//     - Latency: req sampled at edge t gives grant visible after edge t (one clock).
//     - If en=0 or req=0: stay in IDLE, outputs remain 0.
//   GRANT: timer increments by 1 each cycle and saturates at TIMEOUT.
//     Release conditions, evaluated at each edge in priority order:
//       1. en=0                   -> release, no timeout_evt.
//       2. done=1                 -> release.
//       3. req[grant_id]=0        -> release (requester withdrew).
//       4. TIMEOUT!=0 and timer==TIMEOUT-1 -> release and pulse timeout_evt=1 for one cycle.
//     On release: last_id=grant_id, grant=0, grant_id=0, grant_valid=0, go to IDLE.
//     Simultaneous done and timeout expiry: done wins and no timeout_evt.
//   Gap: at least one IDLE cycle separates consecutive grants. Back-to-back grants have a 2-cycle period.
//   Fairness:
//     - The previous grantee has the lowest priority in the next search.
//     - With all N requesting continuously, grants cycle 0,1,...,N-1,0,...
//   Other req bits changing during GRANT do not affect the current grant.
//   done and req edges while in IDLE are ignored, apart from the arbitration scan.
//   Reset mid-GRANT: all outputs clear asynchronously and last_id returns to N-1.
//     The first grant after reset therefore goes to the lowest set index.
//   Indices >= N never appear on grant_id.
// TESTING
//   1. Reset: rst_n=0 with req=all-ones.
//      -> grant=0, grant_valid=0, grant_id=0.
//      -> Release with en=1: grant_id=0 after the first edge.
//   2. Round robin: en=1, req=15'h7FFF held, done pulsed 1 cycle after each grant.
//      -> grant_id sequence 0,1,2,...,14,0, each grant 2 cycles apart.
//   3. Fairness skip: last_id=3, req=15'h0009 (bits 0,3).
//      -> grant_id=0; after its release with req unchanged -> grant_id=3.
//   4. Timeout: TIMEOUT=4, req[5] held, done=0.
//      -> grant_valid high exactly 4 cycles, then timeout_evt=1 for one cycle.
//      -> Re-grant to 5 after one IDLE cycle.
//   5. Simultaneous events: done=1 on the same edge where timer==TIMEOUT-1.
//      -> Release with timeout_evt=0.
//      Separately: en drops mid-GRANT -> release next edge, no re-grant while en=0.
//   6. Async reset mid-GRANT: grant_id=7 active, rst_n pulsed low between edges.
//      -> Outputs clear immediately.
//      -> After reset, req=15'h0081 gives grant_id=0.

Source files
------------

// File: rtl/rr_request_arbiter.sv
// Registered round-robin arbiter: grants one of N requesters at a time and holds
// the grant until en drops, done, the grantee withdraws, or the hold timer expires.
module rr_request_arbiter #(
    parameter int unsigned N       = 15,
    parameter int unsigned IDW     = 4,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TW      = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [N-1:0]   req,
    input  logic           done,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           grant_valid,
    output logic           timeout_evt
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t         r_state,   w_state_nxt;
    logic [N-1:0]   r_grant,   w_grant_nxt;
    logic [IDW-1:0] r_id,      w_id_nxt;
    logic           r_valid,   w_valid_nxt;
    logic           r_tevt,    w_tevt_nxt;
    logic [TW-1:0]  r_timer,   w_timer_nxt;
    logic [IDW-1:0] r_last,    w_last_nxt;

    logic           w_any;
    logic [IDW-1:0] w_pick;
    int unsigned    w_dist;
    int unsigned    w_best;
    logic           w_hold;
    logic           w_expire;

    // Rotating priority: distance 1 is the index right after last_id, distance N
    // is last_id itself, so the previous grantee always ranks lowest.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_best = N + 1;
        w_dist = 0;
        for (int unsigned j = 0; j < N; j++) begin
            if (j > int'(r_last)) begin
                w_dist = j - int'(r_last);
            end else begin
                w_dist = j + N - int'(r_last);
            end
            if (req[j] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_pick = IDW'(j);
                w_any  = 1'b1;
            end
        end
    end

    assign w_hold   = |(req & r_grant);
    assign w_expire = (TIMEOUT != 0) && (r_timer == TW'(TIMEOUT - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_id_nxt    = r_id;
        w_valid_nxt = r_valid;
        w_tevt_nxt  = 1'b0;
        w_timer_nxt = r_timer;
        w_last_nxt  = r_last;
        case (r_state)
            S_IDLE: begin
                if (en && w_any) begin
                    w_state_nxt = S_GRANT;
                    w_grant_nxt = N'(1) << w_pick;
                    w_id_nxt    = w_pick;
                    w_valid_nxt = 1'b1;
                    w_timer_nxt = '0;
                end
            end
            S_GRANT: begin
                if (!en || done || !w_hold || w_expire) begin
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = '0;
                    w_id_nxt    = '0;
                    w_valid_nxt = 1'b0;
                    w_timer_nxt = '0;
                    w_last_nxt  = r_id;
                    // Only an expiry that no higher-priority release pre-empted is reported.
                    w_tevt_nxt  = en && !done && w_hold && w_expire;
                end else if (r_timer != TW'(TIMEOUT)) begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
                w_id_nxt    = '0;
                w_valid_nxt = 1'b0;
                w_timer_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_id    <= '0;
            r_valid <= 1'b0;
            r_tevt  <= 1'b0;
            r_timer <= '0;
            r_last  <= IDW'(N - 1);
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_id    <= w_id_nxt;
            r_valid <= w_valid_nxt;
            r_tevt  <= w_tevt_nxt;
            r_timer <= w_timer_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign grant       = r_grant;
    assign grant_id    = r_id;
    assign grant_valid = r_valid;
    assign timeout_evt = r_tevt;

endmodule
